spi_master_cfg: RTL and testbench
=================================

SPI_MASTER_CFG -- requirements
Module: spi_master_cfg

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning bits per transfer (legal 2..32).
REQ-002 SHALL have parameter CS_INST, default 1, meaning number of active-low chip selects, one per slave (legal 1..16).
REQ-003 SHALL have parameter DIV_W, default 8, meaning width of the clock-divider control.
REQ-004 SHALL have port clk, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset; it is synchronous and active-high.
REQ-006 SHALL have port tx_valid, input, 1, meaning a transfer request is present.
REQ-007 SHALL have port tx_ready, output, 1, meaning the block can accept a request.
REQ-008 SHALL have port tx_data, input, DATA_W, meaning the word to serialise.
REQ-009 SHALL have port cs_sel, input, $clog2(CS_INST) (min 1), meaning the target slave index.
REQ-010 SHALL have ports cpol and cpha, input, 1 each, meaning the SPI mode.
REQ-011 SHALL have port lsb_first, input, 1, meaning 1 = LSB first, 0 = MSB first.
REQ-012 SHALL have port clk_div, input, DIV_W, meaning half-period H = clk_div+1 clk cycles.
REQ-013 SHALL have port rx_valid, output, 1, meaning a one-cycle pulse when rx_data is valid.
REQ-014 SHALL have port rx_data, output, DATA_W, meaning the de-serialised word read from sdi.
REQ-015 SHALL have port busy, output, 1, meaning the state is not IDLE.
REQ-016 SHALL have ports scl (output, 1, serial clock), cs_n (output, CS_INST, chip selects), sdi (input, 1, MISO) and sdo (output, 1, MOSI).

Function
REQ-017 SHALL accept a request on a cycle with tx_valid && tx_ready; tx_ready SHALL be 1 only in IDLE.
REQ-018 SHALL latch tx_data, cs_sel, cpol, cpha, lsb_first and clk_div on accept; input changes during the transfer SHALL be ignored.
REQ-019 SHALL implement states IDLE -> SETUP -> XFER -> HOLD -> IDLE, with no other transitions except reset.
REQ-020 SHALL enter SETUP the cycle after accept with cs_n[cs_sel]=0 and all other cs_n bits 1; SETUP SHALL last H cycles with scl at latched cpol.
REQ-021 SHALL remain in XFER for exactly 2*DATA_W*H cycles, toggling scl at every H-cycle boundary, giving DATA_W leading and DATA_W trailing edges.
REQ-022 With cpha=0, the first bit SHALL be on sdo from SETUP entry, sdi SHALL be sampled on each leading edge, and sdo SHALL advance on each trailing edge except the last.
REQ-023 With cpha=1, sdo SHALL advance on each leading edge (first bit driven on the first leading edge), and sdi SHALL be sampled on each trailing edge.
REQ-024 Bit order SHALL follow latched lsb_first for both sdo and rx_data assembly.
REQ-025 HOLD SHALL last H cycles with scl=cpol and cs_n still asserted, then go to IDLE with all cs_n=1.
REQ-026 On the first IDLE cycle after HOLD, rx_valid SHALL be 1 for one cycle with rx_data updated; rx_data SHALL hold until the next rx_valid; tx_ready SHALL be 1 in that same cycle.
REQ-027 Accept-to-rx_valid latency SHALL be 1 + H*(2*DATA_W+2) cycles; back-to-back requests SHALL incur no extra gap.
REQ-028 If cs_sel >= CS_INST, the transfer SHALL run with full timing but all cs_n SHALL stay 1.
REQ-029 In IDLE, scl SHALL equal the current cpol input, registered one cycle; sdo SHALL be 0.
REQ-030 The divider counter SHALL be DIV_W bits; clk_div = 2^DIV_W-1 SHALL work without overflow.

Reset
REQ-031 When rst=1, the block SHALL go to IDLE on the next clk edge, overriding any transfer in progress.
REQ-032 Reset values SHALL be: cs_n all 1, scl 0, sdo 0, rx_valid 0, rx_data 0, busy 0, tx_ready 0 while rst=1, then 1 the cycle after rst falls.
REQ-033 A transfer aborted by reset SHALL produce no rx_valid pulse.

Verification
REQ-034 Mode 0, DATA_W=8, clk_div=0, MSB first, tx 0xA5, sdi looped to sdo -> rx_valid 19 cycles after accept, rx_data=0xA5, 8 rising scl edges.
REQ-035 Mode 3, lsb_first=1, clk_div=3, tx 0x3C, slave returns 0x81 -> sdo bit order 0,0,1,1,1,1,0,0; rx_data=0x81; latency 73 cycles; scl idles 1.
REQ-036 CS_INST=4, cs_sel=2 -> only cs_n[2] low during SETUP..HOLD; cs_sel=5 -> cs_n stays 4'hF and rx_valid still pulses.
REQ-037 Change cpol, cpha, tx_data and clk_div mid-XFER -> the waveform is unchanged from the latched values.
REQ-038 Assert rst during XFER bit 4 -> next cycle cs_n all 1, scl 0, busy 0, no rx_valid.
REQ-039 Hold tx_valid high for two words -> the second word is accepted on the rx_valid cycle of the first, and cs_n re-asserts the next cycle.

Source files
------------

// File: rtl/spi_master_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master_cfg
//  Purpose  : Configurable SPI master. Accepts one word per request, serialises
//             it on sdo, de-serialises sdi, and reports the received word with
//             a one-cycle rx_valid pulse. Mode, bit order, target slave and
//             serial-clock divider are captured per transfer.
//  Ports    : clk, rst            - system clock, synchronous active-high reset
//             tx_valid/tx_ready   - request handshake (ready only when idle)
//             tx_data             - word to send
//             cs_sel              - target slave index (out of range = no CS)
//             cpol, cpha          - SPI mode
//             lsb_first           - bit order for both directions
//             clk_div             - serial half-period H = clk_div + 1 cycles
//             rx_valid, rx_data   - received word and its strobe
//             busy                - transfer in progress
//             scl, cs_n, sdo, sdi - SPI bus
//  Revision : 1.0 - initial release
// ============================================================================
module spi_master_cfg #(
   parameter int DATA_W  = 8,
   parameter int CS_INST = 1,
   parameter int DIV_W   = 8
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          tx_valid,
   output logic                                          tx_ready,
   input  logic [DATA_W-1:0]                             tx_data,
   input  logic [((CS_INST > 1) ? $clog2(CS_INST) : 1)-1:0] cs_sel,
   input  logic                                          cpol,
   input  logic                                          cpha,
   input  logic                                          lsb_first,
   input  logic [DIV_W-1:0]                              clk_div,
   output logic                                          rx_valid,
   output logic [DATA_W-1:0]                             rx_data,
   output logic                                          busy,
   output logic                                          scl,
   output logic [CS_INST-1:0]                            cs_n,
   input  logic                                          sdi,
   output logic                                          sdo
);

   // One XFER half-period per scl edge; index 0 is the first leading edge.
   localparam int                  c_EDGE_W    = $clog2(2 * DATA_W);
   localparam logic [c_EDGE_W-1:0] c_LAST_EDGE = c_EDGE_W'(2 * DATA_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_XFER  = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [DATA_W-1:0]   r_sh;
   logic [DATA_W-1:0]   r_rx;
   logic [DATA_W-1:0]   r_rx_data;
   logic [DIV_W-1:0]    r_div;
   logic [DIV_W-1:0]    r_cnt;
   logic [c_EDGE_W-1:0] r_edge;
   logic                r_cpha;
   logic                r_lsb;
   logic                r_scl;
   logic                r_sdo;
   logic                r_rx_valid;
   logic                r_tx_ready;
   logic [CS_INST-1:0]  r_cs_n;

   logic                w_accept;
   logic                w_tick;
   logic                w_evt;
   logic                w_lead;
   logic                w_sample;
   logic                w_advance;
   logic                w_done;
   logic [c_EDGE_W-1:0] w_k;
   logic [CS_INST-1:0]  w_cs_dec;
   logic                w_first_bit;
   logic [DATA_W-1:0]   w_tx_shift;
   logic                w_next_bit;
   logic [DATA_W-1:0]   w_sh_shift;

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = (r_state == ST_IDLE) && tx_valid && r_tx_ready;
      w_tick      = (r_cnt == r_div);
      // w_k is the index of the half-period that starts on this tick.
      w_k         = (r_state == ST_SETUP) ? '0 : r_edge + 1'b1;
      w_evt       = w_tick && ((r_state == ST_SETUP) ||
                               ((r_state == ST_XFER) && (r_edge != c_LAST_EDGE)));
      w_lead      = ~w_k[0];
      w_sample    = w_evt && (r_cpha ? ~w_lead : w_lead);
      // cpha=0 already has its first bit out, so it shifts on trailing edges
      // except the final one; cpha=1 drives every bit on a leading edge.
      w_advance   = w_evt && (r_cpha ? w_lead : (~w_lead && (w_k != c_LAST_EDGE)));
      w_done      = (r_state == ST_HOLD) && w_tick;

      case (r_state)
         ST_IDLE:  if (w_accept) w_state_nxt = ST_SETUP;
         ST_SETUP: if (w_tick) w_state_nxt = ST_XFER;
         ST_XFER:  if (w_tick && (r_edge == c_LAST_EDGE)) w_state_nxt = ST_HOLD;
         ST_HOLD:  if (w_tick) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase

      // Slave indices beyond CS_INST match no bit, leaving every select high.
      w_cs_dec = '1;
      for (int i = 0; i < CS_INST; i++) begin
         if (32'(cs_sel) == i) w_cs_dec[i] = 1'b0;
      end

      w_first_bit = lsb_first ? tx_data[0] : tx_data[DATA_W-1];
      w_tx_shift  = lsb_first ? {1'b0, tx_data[DATA_W-1:1]} : {tx_data[DATA_W-2:0], 1'b0};
      w_next_bit  = r_lsb ? r_sh[0] : r_sh[DATA_W-1];
      w_sh_shift  = r_lsb ? {1'b0, r_sh[DATA_W-1:1]} : {r_sh[DATA_W-2:0], 1'b0};
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sh       <= '0;
         r_rx       <= '0;
         r_rx_data  <= '0;
         r_div      <= '0;
         r_cnt      <= '0;
         r_edge     <= '0;
         r_cpha     <= 1'b0;
         r_lsb      <= 1'b0;
         r_scl      <= 1'b0;
         r_sdo      <= 1'b0;
         r_rx_valid <= 1'b0;
         r_tx_ready <= 1'b0;
         r_cs_n     <= '1;
      end else begin
         r_rx_valid <= w_done;
         r_tx_ready <= (w_state_nxt == ST_IDLE);

         // Divider never exceeds r_div, so the all-ones setting cannot wrap.
         if ((r_state == ST_IDLE) || w_tick) r_cnt <= '0;
         else                                r_cnt <= r_cnt + 1'b1;

         if (w_evt) r_edge <= w_k;

         // Idle scl tracks the live cpol input; during a transfer it only
         // toggles on half-period boundaries.
         if ((r_state == ST_IDLE) || w_done) r_scl <= cpol;
         else if (w_evt)                     r_scl <= ~r_scl;

         if (w_accept) begin
            r_div  <= clk_div;
            r_cpha <= cpha;
            r_lsb  <= lsb_first;
            r_cs_n <= w_cs_dec;
            r_sdo  <= cpha ? 1'b0 : w_first_bit;
            r_sh   <= cpha ? tx_data : w_tx_shift;
         end else if (w_advance) begin
            r_sdo  <= w_next_bit;
            r_sh   <= w_sh_shift;
         end else if (w_done) begin
            r_sdo  <= 1'b0;
            r_cs_n <= '1;
         end

         if (w_sample) r_rx <= r_lsb ? {sdi, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], sdi};
         if (w_done)   r_rx_data <= r_rx;
      end
   end

   assign tx_ready = r_tx_ready;
   assign rx_valid = r_rx_valid;
   assign rx_data  = r_rx_data;
   assign busy     = (r_state != ST_IDLE);
   assign scl      = r_scl;
   assign cs_n     = r_cs_n;
   assign sdo      = r_sdo;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_master_cfg
//  Purpose  : Self-checking bench for spi_master_cfg (DATA_W=8, CS_INST=5,
//             DIV_W=4). A bus-level slave model answers on sdi and captures
//             sdo; expectations come from a table and a transfer-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_cfg;

   localparam int DW  = 8;
   localparam int CSN = 5;
   localparam int DVW = 4;
   localparam int CSW = 3;

   typedef struct packed {
      logic [DW-1:0]  data;
      logic [CSW-1:0] sel;
      logic           cpol;
      logic           cpha;
      logic           lsb;
      logic [DVW-1:0] div;
      logic [DW-1:0]  slave;
      logic           loopb;
      logic           scramble;
      logic [DW-1:0]  exp_rx;
      logic [15:0]    exp_lat;
      logic [CSN-1:0] exp_cs;
   } vec_t;

   logic           clk = 1'b0;
   logic           rst;
   logic           tx_valid;
   logic           tx_ready;
   logic [DW-1:0]  tx_data;
   logic [CSW-1:0] cs_sel;
   logic           cpol;
   logic           cpha;
   logic           lsb_first;
   logic [DVW-1:0] clk_div;
   logic           rx_valid;
   logic [DW-1:0]  rx_data;
   logic           busy;
   logic           scl;
   logic [CSN-1:0] cs_n;
   logic           sdi;
   logic           sdo;
   logic           sdi_slave;
   logic           loop_en;

   int n_vec;
   int n_err;

   assign sdi = loop_en ? sdo : sdi_slave;

   always #5 clk = ~clk;

   spi_master_cfg #(.DATA_W(DW), .CS_INST(CSN), .DIV_W(DVW)) dut (
      .clk      (clk),
      .rst      (rst),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_data  (tx_data),
      .cs_sel   (cs_sel),
      .cpol     (cpol),
      .cpha     (cpha),
      .lsb_first(lsb_first),
      .clk_div  (clk_div),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .busy     (busy),
      .scl      (scl),
      .cs_n     (cs_n),
      .sdi      (sdi),
      .sdo      (sdo)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic bit_at(input logic [DW-1:0] w, input logic lsb, input int i);
      if (i < 0 || i >= DW) return 1'b0;
      return lsb ? w[i] : w[DW-1-i];
   endfunction

   function automatic logic [DW-1:0] rev(input logic [DW-1:0] w);
      logic [DW-1:0] r;
      for (int i = 0; i < DW; i++) r[i] = w[DW-1-i];
      return r;
   endfunction

   // Transfer-level expectations: timing from H, data from the slave (or
   // the sent word when looped back), one select low only for a valid index.
   function automatic vec_t model(input vec_t v);
      vec_t r;
      r         = v;
      r.exp_lat = 16'(1 + (int'(v.div) + 1) * (2 * DW + 2));
      r.exp_rx  = v.loopb ? v.data : v.slave;
      r.exp_cs  = ~(CSN'(1) << v.sel);
      return r;
   endfunction

   function automatic vec_t mk(input logic [7:0] d, input logic [2:0] s, input logic po,
                               input logic ph, input logic l, input logic [3:0] dv,
                               input logic [7:0] sl, input logic lb, input logic sc,
                               input logic [7:0] er, input int el, input logic [4:0] ec);
      vec_t v;
      v.data = d; v.sel = s; v.cpol = po; v.cpha = ph; v.lsb = l; v.div = dv;
      v.slave = sl; v.loopb = lb; v.scramble = sc;
      v.exp_rx = er; v.exp_lat = 16'(el); v.exp_cs = ec;
      return v;
   endfunction

   // Called at a negedge. Requests v, monitors the bus cycle by cycle and
   // returns at the negedge of the rx_valid cycle; with chain set, the next
   // request is already presented there so it is taken with no gap.
   task automatic run_xfer(input vec_t v, input bit chain, input vec_t nxt);
      int            cyc, lat, lead, trail, rises, cs_bad;
      logic          prev_scl;
      logic [DW-1:0] mosi;
      bit            seen;
      tx_valid = 1'b1; tx_data = v.data; cs_sel = v.sel; cpol = v.cpol; cpha = v.cpha;
      lsb_first = v.lsb; clk_div = v.div; loop_en = v.loopb;
      cyc = 0;
      while (tx_ready !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("tx_ready_at_request", 32'(tx_ready), 32'(1));
      @(negedge clk);
      if (!chain) tx_valid = 1'b0;
      sdi_slave = v.cpha ? 1'b0 : bit_at(v.slave, v.lsb, 0);
      chk("setup_scl", 32'(scl), 32'(v.cpol));
      prev_scl = scl; lead = 0; trail = 0; rises = 0; cs_bad = 0; mosi = '0; seen = 0; lat = -1;
      for (cyc = 1; cyc <= int'(v.exp_lat) + 8; cyc++) begin
         if (rx_valid === 1'b1) begin
            seen = 1;
            lat  = cyc;
            break;
         end
         if (busy !== 1'b1 || cs_n !== v.exp_cs) cs_bad++;
         if (scl !== prev_scl) begin
            if (scl === 1'b1) rises++;
            if (lead == trail) begin
               lead++;
               if (v.cpha) sdi_slave = bit_at(v.slave, v.lsb, lead - 1);
               else if (lead <= DW) mosi[lead-1] = sdo;
            end else begin
               trail++;
               if (v.cpha) begin
                  if (trail <= DW) mosi[trail-1] = sdo;
               end else begin
                  sdi_slave = bit_at(v.slave, v.lsb, trail);
               end
            end
         end
         prev_scl = scl;
         if (v.scramble && cyc == int'(v.exp_lat) / 2) begin
            tx_data = ~v.data; cpol = ~v.cpol; cpha = ~v.cpha; lsb_first = ~v.lsb;
            clk_div = v.div + 4'd5; cs_sel = v.sel + 3'd1;
         end
         @(negedge clk);
      end
      chk("latency", 32'(lat), 32'(v.exp_lat));
      chk("rx_data", 32'(rx_data), 32'(v.exp_rx));
      chk("mosi_bits", 32'(mosi), 32'(v.lsb ? v.data : rev(v.data)));
      chk("scl_rising_edges", 32'(rises), 32'(DW));
      chk("scl_edges", 32'(lead + trail), 32'(2 * DW));
      chk("busy_cs_bad_cycles", 32'(cs_bad), 32'(0));
      if (seen) begin
         chk("ready_on_done", 32'(tx_ready), 32'(1));
         chk("cs_idle", 32'(cs_n), 32'(5'h1F));
         chk("scl_idle", 32'(scl), 32'(cpol));
         chk("sdo_idle", 32'(sdo), 32'(0));
      end
      if (chain) begin
         tx_data = nxt.data; cs_sel = nxt.sel; cpol = nxt.cpol; cpha = nxt.cpha;
         lsb_first = nxt.lsb; clk_div = nxt.div; loop_en = nxt.loopb;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      vec_t tbl [8];
      vec_t rv;
      int   pulses;
      n_vec = 0; n_err = 0;
      rst = 1'b1; tx_valid = 1'b0; tx_data = '0; cs_sel = '0; cpol = 1'b0; cpha = 1'b0;
      lsb_first = 1'b0; clk_div = '0; loop_en = 1'b0; sdi_slave = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_cs_n", 32'(cs_n), 32'(5'h1F));
      chk("rst_scl", 32'(scl), 32'(0));
      chk("rst_sdo", 32'(sdo), 32'(0));
      chk("rst_rx_valid", 32'(rx_valid), 32'(0));
      chk("rst_rx_data", 32'(rx_data), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_tx_ready", 32'(tx_ready), 32'(0));
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 32'(tx_ready), 32'(1));

      //            data   sel po ph lsb div slave  lb sc exp_rx lat  cs
      tbl[0] = mk(8'hA5, 3'd0, 0, 0, 0, 4'd0, 8'h00, 1, 0, 8'hA5,  19, 5'h1E);
      tbl[1] = mk(8'h3C, 3'd0, 1, 1, 1, 4'd3, 8'h81, 0, 0, 8'h81,  73, 5'h1E);
      tbl[2] = mk(8'h96, 3'd2, 0, 1, 0, 4'd1, 8'h4E, 0, 0, 8'h4E,  37, 5'h1B);
      tbl[3] = mk(8'h11, 3'd5, 1, 0, 1, 4'd0, 8'hC3, 0, 0, 8'hC3,  19, 5'h1F);
      tbl[4] = mk(8'hE7, 3'd3, 0, 0, 0, 4'd2, 8'h2D, 0, 1, 8'h2D,  55, 5'h17);
      tbl[5] = mk(8'h69, 3'd4, 1, 1, 0, 4'd15, 8'hF0, 0, 0, 8'hF0, 289, 5'h0F);
      tbl[6] = mk(8'hC5, 3'd1, 0, 0, 0, 4'd0, 8'h33, 0, 0, 8'h33,  19, 5'h1D);
      tbl[7] = mk(8'h0F, 3'd0, 0, 1, 1, 4'd1, 8'hAA, 0, 0, 8'hAA,  37, 5'h1E);

      for (int i = 0; i < 8; i++) begin
         run_xfer(tbl[i], (i == 6), tbl[(i + 1) % 8]);
      end

      for (int i = 0; i < 24; i++) begin
         rv.data     = DW'($urandom);
         rv.sel      = CSW'($urandom_range(0, 7));
         rv.cpol     = 1'($urandom);
         rv.cpha     = 1'($urandom);
         rv.lsb      = 1'($urandom);
         rv.div      = ($urandom_range(0, 9) == 0) ? 4'd15 : DVW'($urandom_range(0, 3));
         rv.slave    = DW'($urandom);
         rv.loopb    = ($urandom_range(0, 3) == 0);
         rv.scramble = 1'($urandom);
         rv = model(rv);
         run_xfer(rv, 1'b0, rv);
      end

      // Reset in the middle of the fifth bit of a mode-0, H=1 transfer.
      tx_valid = 1'b1; tx_data = 8'h5A; cs_sel = 3'd1; cpol = 1'b0; cpha = 1'b0;
      lsb_first = 1'b0; clk_div = '0; loop_en = 1'b1;
      for (int k = 0; k < 20 && tx_ready !== 1'b1; k++) @(negedge clk);
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (9) @(negedge clk);
      chk("abort_busy_before", 32'(busy), 32'(1));
      rst = 1'b1;
      @(negedge clk);
      chk("abort_cs_n", 32'(cs_n), 32'(5'h1F));
      chk("abort_scl", 32'(scl), 32'(0));
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_rx_valid", 32'(rx_valid), 32'(0));
      chk("abort_tx_ready", 32'(tx_ready), 32'(0));
      rst = 1'b0;
      pulses = 0;
      @(negedge clk);
      chk("abort_ready_after", 32'(tx_ready), 32'(1));
      repeat (30) begin
         if (rx_valid === 1'b1) pulses++;
         @(negedge clk);
      end
      chk("abort_rx_pulses", 32'(pulses), 32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
